// File: rtl/fc_pkg.sv
// Shared Fibre Channel definitions: ordered-set words, primitive decode and
// the CRC-32 step used by both the RX checker and the TX side.
package fc;

   typedef enum logic [3:0] {
      PRIM_NONE,
      PRIM_SOF,
      PRIM_EOFN,
      PRIM_EOFT,
      PRIM_EOFA,
      PRIM_EOFNI,
      PRIM_R_RDY,
      PRIM_BB_SCS,
      PRIM_BB_SCR,
      PRIM_VC_RDY
   } prim_e;

   // Ordered-set words as delivered by the framer (K28.5 first).
   localparam logic [31:0] OS_SOFI3  = 32'hBCB55656;
   localparam logic [31:0] OS_SOFN3  = 32'hBCB53636;
   localparam logic [31:0] OS_EOFN   = 32'hBC95D5D5;
   localparam logic [31:0] OS_EOFT   = 32'hBC957575;
   localparam logic [31:0] OS_EOFA   = 32'hBC95F5F5;
   localparam logic [31:0] OS_EOFNI  = 32'hBC8AD5D5;
   localparam logic [31:0] OS_R_RDY  = 32'hBC954A4A;
   localparam logic [31:0] OS_BB_SCS = 32'hBC959696;
   localparam logic [31:0] OS_BB_SCR = 32'hBCB5CACA;
   localparam logic [15:0] OS_VC_RDY_HI = 16'hBCF5;

   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

   // Counter indices, which are also the MM read addresses.
   localparam int CNT_NUM = 6;

   function automatic prim_e map_primitive(logic [31:0] word);
      prim_e p;
      p = PRIM_NONE;
      case (word)
         OS_SOFI3, OS_SOFN3: p = PRIM_SOF;
         OS_EOFN:            p = PRIM_EOFN;
         OS_EOFT:            p = PRIM_EOFT;
         OS_EOFA:            p = PRIM_EOFA;
         OS_EOFNI:           p = PRIM_EOFNI;
         OS_R_RDY:           p = PRIM_R_RDY;
         OS_BB_SCS:          p = PRIM_BB_SCS;
         OS_BB_SCR:          p = PRIM_BB_SCR;
         default: begin
            if (word[31:16] == OS_VC_RDY_HI) p = PRIM_VC_RDY;
         end
      endcase
      return p;
   endfunction

   // One 32-bit word through the CRC-32 register, bit 31 first, no reflection.
   function automatic logic [31:0] crc32_update(logic [31:0] crc, logic [31:0] data);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ data[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return c;
   endfunction

endpackage

// File: rtl/fc_rx_frame_counters.sv
// Per-event counters for the RX frame checker plus the registered MM read port.
module fc_rx_frame_counters
   import fc::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inc_good,
   input  logic        inc_crc_err,
   input  logic        inc_abort,
   input  logic        inc_framing,
   input  logic        inc_runt,
   input  logic        inc_rrdy,
   input  logic [2:0]  mm_address,
   input  logic        mm_read,
   output logic [31:0] mm_readdata
);

   logic [31:0]        cnt_q [CNT_NUM];
   logic [CNT_NUM-1:0] inc;
   logic [31:0]        rd_mux;

   assign inc = {inc_rrdy, inc_runt, inc_framing, inc_abort, inc_crc_err, inc_good};

   // Event counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      // NOTE: these counters are architectural state read by software, so every entry is reset.
      if (!reset_n) begin
         for (int i = 0; i < CNT_NUM; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < CNT_NUM; i++) begin
            if (inc[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
         end
      end
   end

   // Read mux over the pre-increment counter values; unused addresses read all-ones.
   always_comb begin
      rd_mux = 32'hFFFFFFFF;
      case (mm_address)
         3'd0: rd_mux = cnt_q[0];
         3'd1: rd_mux = cnt_q[1];
         3'd2: rd_mux = cnt_q[2];
         3'd3: rd_mux = cnt_q[3];
         3'd4: rd_mux = cnt_q[4];
         3'd5: rd_mux = cnt_q[5];
         default: rd_mux = 32'hFFFFFFFF;
      endcase
   end

   // Read data register, updated only on a read strobe.
   always_ff @(posedge clk) begin
      if (!reset_n)     mm_readdata <= '0;
      else if (mm_read) mm_readdata <= rd_mux;
   end

endmodule

// File: rtl/fc_rx_frame_checker.sv
// FC RX frame checker: strips SOF/EOF/CRC words from the framer stream, checks
// CRC-32, emits header+payload as Avalon-ST and diverts single-word primitives.
module fc_rx_frame_checker
   import fc::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_startofpacket,
   input  logic        in_endofpacket,
   output logic [31:0] out_data,
   output logic        out_valid,
   output logic        out_startofpacket,
   output logic        out_endofpacket,
   output logic        out_error,
   output logic [1:0]  out_empty,
   output logic [31:0] prim_data,
   output logic        prim_valid,
   input  logic [2:0]  mm_address,
   input  logic        mm_read,
   output logic [31:0] mm_readdata
);

   typedef enum logic {IDLE, IN_FRAME} state_e;

   state_e      state_q, state_d;
   logic [31:0] h0_q, h0_d, h1_q, h1_d;
   logic        h0_v_q, h0_v_d, h1_v_q, h1_v_d;
   logic        started_q, started_d;
   logic [31:0] crc_q, crc_d;

   logic        emit, emit_sop, emit_eop, emit_err, prim_hit;
   logic [31:0] crc_fin;
   logic        crc_bad, eof_abort;
   logic        ev_good, ev_crc_err, ev_abort, ev_framing, ev_runt, ev_rrdy;
   prim_e       in_prim;

   assign in_prim   = map_primitive(in_data);
   assign out_empty = 2'b00;

   // Next-state logic for the frame FSM, hold pipe and running CRC.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      h0_d       = h0_q;
      h0_v_d     = h0_v_q;
      h1_d       = h1_q;
      h1_v_d     = h1_v_q;
      started_d  = started_q;
      crc_d      = crc_q;
      emit       = 1'b0;
      emit_sop   = 1'b0;
      emit_eop   = 1'b0;
      emit_err   = 1'b0;
      prim_hit   = 1'b0;
      ev_good    = 1'b0;
      ev_crc_err = 1'b0;
      ev_abort   = 1'b0;
      ev_framing = 1'b0;
      ev_runt    = 1'b0;
      ev_rrdy    = 1'b0;
      // At EOF h1 is the last payload word and h0 the received CRC.
      crc_fin    = ~crc32_update(crc_q, h1_q);
      crc_bad    = (crc_fin != h0_q);
      eof_abort  = (in_prim == PRIM_EOFA) || (in_prim == PRIM_EOFNI);

      if (in_valid) begin
         if (in_startofpacket && in_endofpacket) begin
            // Single-word primitive: side channel only, frame state untouched.
            prim_hit = 1'b1;
            ev_rrdy  = (in_prim == PRIM_R_RDY);
         end else if (in_startofpacket) begin
            if (state_q == IN_FRAME) begin
               // SOF inside a frame: close any open output frame as errored, then restart.
               ev_framing = 1'b1;
               if (started_q) begin
                  emit     = 1'b1;
                  emit_eop = 1'b1;
                  emit_err = 1'b1;
               end
            end
            state_d   = IN_FRAME;
            crc_d     = CRC_INIT;
            h0_v_d    = 1'b0;
            h1_v_d    = 1'b0;
            started_d = 1'b0;
         end else if (state_q == IDLE) begin
            ev_framing = 1'b1;
         end else if (!in_endofpacket) begin
            h0_d   = in_data;
            h0_v_d = 1'b1;
            h1_d   = h0_q;
            h1_v_d = h0_v_q;
            if (h1_v_q) begin
               emit      = 1'b1;
               emit_sop  = !started_q;
               started_d = 1'b1;
               crc_d     = crc32_update(crc_q, h1_q);
            end
         end else begin
            if (h0_v_q && h1_v_q) begin
               emit       = 1'b1;
               emit_sop   = !started_q;
               emit_eop   = 1'b1;
               emit_err   = crc_bad || eof_abort;
               ev_crc_err = crc_bad;
               ev_abort   = !crc_bad && eof_abort;
               ev_good    = !crc_bad && !eof_abort;
            end else begin
               ev_runt = 1'b1;
            end
            state_d   = IDLE;
            h0_v_d    = 1'b0;
            h1_v_d    = 1'b0;
            started_d = 1'b0;
         end
      end
   end

   // Frame state registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset_n) begin
         state_q   <= IDLE;
         h0_q      <= '0;
         h0_v_q    <= 1'b0;
         h1_q      <= '0;
         h1_v_q    <= 1'b0;
         started_q <= 1'b0;
         crc_q     <= CRC_INIT;
      end else begin
         state_q   <= state_d;
         h0_q      <= h0_d;
         h0_v_q    <= h0_v_d;
         h1_q      <= h1_d;
         h1_v_q    <= h1_v_d;
         started_q <= started_d;
         crc_q     <= crc_d;
      end
   end

   // Registered Avalon-ST and primitive outputs; flags are zero on non-beat cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_data          <= '0;
         out_valid         <= 1'b0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_error         <= 1'b0;
         prim_data         <= '0;
         prim_valid        <= 1'b0;
      end else begin
         out_valid         <= emit;
         out_startofpacket <= emit && emit_sop;
         out_endofpacket   <= emit && emit_eop;
         out_error         <= emit && emit_err;
         prim_valid        <= prim_hit;
         if (emit)     out_data  <= h1_q;
         if (prim_hit) prim_data <= in_data;
      end
   end

   fc_rx_frame_counters u_counters (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc_good    (ev_good),
      .inc_crc_err (ev_crc_err),
      .inc_abort   (ev_abort),
      .inc_framing (ev_framing),
      .inc_runt    (ev_runt),
      .inc_rrdy    (ev_rrdy),
      .mm_address  (mm_address),
      .mm_read     (mm_read),
      .mm_readdata (mm_readdata)
   );

endmodule

// File: tb/tb_fc_rx_frame_checker.sv
// Self-checking bench for fc_rx_frame_checker: a frame-level model predicts
// every output beat, primitive strobe and counter read.
module tb_fc_rx_frame_checker;

   localparam logic [31:0] W_SOF   = 32'hBCB53636;
   localparam logic [31:0] W_EOFN  = 32'hBC95D5D5;
   localparam logic [31:0] W_EOFA  = 32'hBC95F5F5;
   localparam logic [31:0] W_EOFNI = 32'hBC8AD5D5;
   localparam logic [31:0] W_RRDY  = 32'hBC954A4A;

   logic        clk;
   logic        reset_n;
   logic [31:0] in_data;
   logic        in_valid, in_sop, in_eop;
   logic [31:0] out_data;
   logic        out_valid, out_sop, out_eop, out_error;
   logic [1:0]  out_empty;
   logic [31:0] prim_data;
   logic        prim_valid;
   logic [2:0]  mm_address;
   logic        mm_read;
   logic [31:0] mm_readdata;

   int n_checks = 0;
   int n_errors = 0;
   int beats_seen = 0;
   bit ena = 0;

   // Model state and expected outputs for the next sampled cycle.
   logic [31:0] fq[$];
   logic [31:0] pay[$];
   bit          m_in_frame;
   logic [31:0] m_cnt[6];
   logic        exp_ov, exp_os, exp_oe, exp_err, exp_pv, exp_zero;
   logic [31:0] exp_od, exp_pd, exp_rd;

   fc_rx_frame_checker dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_error         (out_error),
      .out_empty         (out_empty),
      .prim_data         (prim_data),
      .prim_valid        (prim_valid),
      .mm_address        (mm_address),
      .mm_read           (mm_read),
      .mm_readdata       (mm_readdata)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-serial CRC over the low n bits of d, MSB first.
   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [31:0] d, input int n);
      logic fb;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C11DB7;
      end
      return c;
   endfunction

   // Transmitted CRC word for a list of payload words.
   function automatic logic [31:0] frame_crc(input logic [31:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) c = crc_bits(c, q[i], 32);
      return ~c;
   endfunction

   // Frame-level model: a word list per frame, beat k emitted when word k+2 arrives.
   task automatic model_step(input logic [31:0] w, input logic s, input logic e);
      int n;
      logic [31:0] body[$];
      bit bad, abort;
      n = fq.size();
      if (s && e) begin
         exp_pv = 1; exp_pd = w;
         if (w == W_RRDY) m_cnt[5]++;
      end else if (s) begin
         if (m_in_frame) begin
            m_cnt[3]++;
            if (n >= 3) begin
               exp_ov = 1; exp_od = fq[n-2]; exp_oe = 1; exp_err = 1;
            end
         end
         m_in_frame = 1;
         fq.delete();
      end else if (!m_in_frame) begin
         m_cnt[3]++;
      end else if (!e) begin
         fq.push_back(w);
         n = fq.size();
         if (n >= 3) begin
            exp_ov = 1; exp_od = fq[n-3]; exp_os = (n == 3);
         end
      end else begin
         if (n >= 2) begin
            body = fq[0:n-2];
            bad   = (frame_crc(body) != fq[n-1]);
            abort = (w == W_EOFA) || (w == W_EOFNI);
            exp_ov = 1; exp_od = fq[n-2]; exp_os = (n == 2); exp_oe = 1;
            exp_err = bad || abort;
            if (bad)        m_cnt[1]++;
            else if (abort) m_cnt[2]++;
            else            m_cnt[0]++;
         end else begin
            m_cnt[4]++;
         end
         m_in_frame = 0;
      end
   endtask

   // One clock of stimulus, driven just after the falling edge.
   task automatic drive(input logic v, input logic [31:0] w, input logic s, input logic e,
                        input logic rd, input logic [2:0] a);
      @(negedge clk); #1;
      reset_n = 1;
      if (rd) exp_rd = (a < 3'd6) ? m_cnt[a] : 32'hFFFFFFFF;
      exp_ov = 0; exp_os = 0; exp_oe = 0; exp_err = 0; exp_pv = 0; exp_zero = 0;
      if (v) model_step(w, s, e);
      in_valid = v; in_data = w; in_sop = s; in_eop = e;
      mm_read = rd; mm_address = a;
   endtask

   task automatic word(input logic [31:0] w); drive(1, w, 0, 0, 0, 3'd0); endtask
   task automatic sof();                      drive(1, W_SOF, 1, 0, 0, 3'd0); endtask
   task automatic eof(input logic [31:0] w);  drive(1, w, 0, 1, 0, 3'd0); endtask
   task automatic idle();                     drive(0, 32'h0, 0, 0, 0, 3'd0); endtask

   task automatic rst();
      @(negedge clk); #1;
      reset_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0; mm_read = 0;
      fq.delete(); m_in_frame = 0;
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      exp_ov = 0; exp_os = 0; exp_oe = 0; exp_err = 0; exp_pv = 0;
      exp_od = 0; exp_pd = 0; exp_rd = 0; exp_zero = 1;
      ena = 1;
   endtask

   task automatic rd_lit(input logic [2:0] a, input logic [31:0] v, input string name);
      drive(0, 32'h0, 0, 0, 1, a);
      idle();
      check(name, mm_readdata, v);
   endtask

   task automatic send_frame(input logic [31:0] eof_w, input logic [31:0] crc_xor);
      sof();
      foreach (pay[i]) word(pay[i]);
      word(frame_crc(pay) ^ crc_xor);
      eof(eof_w);
      idle();
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (ena) begin
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         check("out_sop", 32'(out_sop), 32'(exp_os));
         check("out_eop", 32'(out_eop), 32'(exp_oe));
         check("out_error", 32'(out_error), 32'(exp_err));
         check("out_empty", 32'(out_empty), 32'h0);
         check("prim_valid", 32'(prim_valid), 32'(exp_pv));
         check("mm_readdata", mm_readdata, exp_rd);
         if (exp_ov) check("out_data", out_data, exp_od);
         if (exp_pv) check("prim_data", prim_data, exp_pd);
         if (exp_zero) begin
            check("rst_out_data", out_data, 32'h0);
            check("rst_prim_data", prim_data, 32'h0);
         end
         if (out_valid) beats_seen++;
      end
   end

   initial begin
      int b0;
      logic [31:0] c;
      reset_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0;
      mm_read = 0; mm_address = 0;

      // Pin the model CRC: standard check string and the codeword residue.
      c = 32'hFFFFFFFF;
      c = crc_bits(c, 32'h31323334, 32);
      c = crc_bits(c, 32'h35363738, 32);
      c = crc_bits(c, 32'h00000039, 8);
      check("model_crc_check", ~c, 32'hFC891918);
      pay = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
      c = 32'hFFFFFFFF;
      foreach (pay[i]) c = crc_bits(c, pay[i], 32);
      c = crc_bits(c, frame_crc(pay), 32);
      check("model_crc_residue", c, 32'hC704DD7B);

      // Good frame with an in_valid gap; a read in the EOF cycle sees the old count.
      rst(); idle();
      b0 = beats_seen;
      sof(); word(32'h1); word(32'h2); idle(); word(32'h3); word(32'h4);
      word(32'h5); idle(); idle(); word(32'h6); word(frame_crc(pay));
      drive(1, W_EOFN, 0, 1, 1, 3'd0);
      idle();
      check("rd_same_cycle", mm_readdata, 32'h0);
      check("good_beats", 32'(beats_seen - b0), 32'd6);
      rd_lit(3'd0, 32'd1, "good_cnt");

      // CRC bit 0 flipped.
      rst(); idle();
      b0 = beats_seen;
      send_frame(W_EOFN, 32'h1);
      check("crcerr_beats", 32'(beats_seen - b0), 32'd6);
      rd_lit(3'd1, 32'd1, "crc_err_cnt");
      rd_lit(3'd0, 32'd0, "good_cnt_after_crcerr");

      // Good CRC but aborted EOF, then invalid EOF.
      rst(); idle();
      send_frame(W_EOFA, 32'h0);
      rd_lit(3'd2, 32'd1, "abort_cnt");
      send_frame(W_EOFNI, 32'h0);
      rd_lit(3'd2, 32'd2, "abort_cnt_ni");

      // R_RDY in the middle of a frame.
      rst(); idle();
      b0 = beats_seen;
      sof(); word(32'h1); word(32'h2); word(32'h3);
      drive(1, W_RRDY, 1, 1, 0, 3'd0);
      word(32'h4); word(32'h5); word(32'h6); word(frame_crc(pay)); eof(W_EOFN); idle();
      check("rrdy_beats", 32'(beats_seen - b0), 32'd6);
      rd_lit(3'd5, 32'd1, "rrdy_cnt");
      rd_lit(3'd0, 32'd1, "good_cnt_rrdy");

      // Runt, SOF-in-frame, EOF and data in IDLE.
      rst(); idle();
      b0 = beats_seen;
      sof(); word(32'hAA); eof(W_EOFN); idle();
      check("runt_beats", 32'(beats_seen - b0), 32'd0);
      rd_lit(3'd4, 32'd1, "runt_cnt");
      b0 = beats_seen;
      sof(); word(32'hA); word(32'hB); word(32'hC); sof(); idle();
      check("sof_in_frame_beats", 32'(beats_seen - b0), 32'd2);
      rd_lit(3'd3, 32'd1, "framing_cnt");
      eof(W_EOFN); word(32'h77); eof(W_EOFN); idle();
      rd_lit(3'd3, 32'd3, "framing_cnt_idle");
      rd_lit(3'd4, 32'd2, "runt_cnt_2");

      // Two-word frame: one beat carrying both sop and eop.
      rst(); idle();
      b0 = beats_seen;
      pay = '{32'h55};
      send_frame(W_EOFN, 32'h0);
      check("two_word_beats", 32'(beats_seen - b0), 32'd1);
      rd_lit(3'd0, 32'd1, "good_cnt_two_word");

      // Reset in the middle of a frame.
      rst(); idle();
      b0 = beats_seen;
      sof(); word(32'h11); word(32'h22); word(32'h33); word(32'h44);
      rst(); idle(); idle(); idle();
      check("reset_beats", 32'(beats_seen - b0), 32'd2);
      for (int a = 0; a < 6; a++) rd_lit(3'(a), 32'd0, "cnt_after_reset");
      rd_lit(3'd6, 32'hFFFFFFFF, "addr6");
      rd_lit(3'd7, 32'hFFFFFFFF, "addr7");
      b0 = beats_seen;
      pay = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
      send_frame(W_EOFN, 32'h0);
      check("post_reset_beats", 32'(beats_seen - b0), 32'd6);
      rd_lit(3'd0, 32'd1, "good_cnt_post_reset");

      idle(); idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
